// File: rtl/pipeline_trace_unit_pkg.sv
// Shared types and constants for the pipeline trace unit: default widths,
// stage indices and the trace record layout.
package pipeline_trace_pkg;

    localparam int unsigned DEF_PC_W    = 16;
    localparam int unsigned DEF_INSTR_W = 16;
    localparam int unsigned DEF_CYC_W   = 32;
    localparam int unsigned DEF_STALL_W = 4;

    localparam int unsigned STAGE_F = 0;
    localparam int unsigned STAGE_D = 1;
    localparam int unsigned STAGE_X = 2;
    localparam int unsigned STAGE_M = 3;
    localparam int unsigned STAGE_W = 4;

    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_CYC_W-1:0]   fetch_cyc;
        logic [DEF_CYC_W-1:0]   retire_cyc;
        logic [DEF_STALL_W-1:0] stall_cnt;
        logic                   flushed;
    } trace_rec_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        return (s > 32'hFFFF) ? 16'hFFFF : 16'(s);
    endfunction

endpackage

// File: rtl/pipeline_trace_unit_fifo.sv
// trace_fifo: synchronous FIFO of trace records with a multi-push port.
// Pushes are taken in index order until free space runs out; the rest are reported as drops.
module trace_fifo
    import pipeline_trace_pkg::*;
#(
    parameter type         rec_t  = trace_rec_t,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PUSH_N = 1,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned DW    = $clog2(PUSH_N + 1)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PUSH_N-1:0] push_valid,
    input  rec_t [PUSH_N-1:0] push_rec,
    output logic              out_valid,
    input  logic              out_ready,
    output rec_t              out_rec,
    output logic              full,
    output logic [AW:0]       count,
    output logic [DW-1:0]     drop_n
);

    rec_t              mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              pop;
    logic [PUSH_N-1:0] accept;
    logic [AW-1:0]     waddr [PUSH_N];
    logic [AW:0]       n_acc;

    assign out_valid = (count != '0);
    assign out_rec   = out_valid ? mem[rd_ptr] : '0;
    assign full      = (32'(count) == DEPTH);

    // A pop in the same cycle frees one entry for this cycle's pushes.
    always_comb begin
        int unsigned free;
        int unsigned acc;
        int unsigned drop;
        pop    = out_valid && out_ready;
        free   = DEPTH - 32'(count) + 32'(pop);
        acc    = 0;
        drop   = 0;
        accept = '0;
        for (int unsigned k = 0; k < PUSH_N; k++) begin
            waddr[k] = wr_ptr + AW'(acc);
            if (push_valid[k]) begin
                if (acc < free) begin
                    accept[k] = 1'b1;
                    acc++;
                end else begin
                    drop++;
                end
            end
        end
        n_acc  = (AW+1)'(acc);
        drop_n = DW'(drop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int unsigned k = 0; k < PUSH_N; k++) begin
                if (accept[k]) mem[waddr[k]] <= push_rec[k];
            end
            wr_ptr <= wr_ptr + AW'(n_acc);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + n_acc - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/pipeline_trace_unit.sv
// Pipeline trace unit: shadows an in-order pipeline under stall/flush and streams retire records.
// Define TRACE_FLUSH_LOG_EN to also emit records for instructions killed by flush.
module pipeline_trace_unit
    import pipeline_trace_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned STALL_UPTO = 1,
    parameter int unsigned FLUSH_UPTO = 1,
    parameter int unsigned PC_W       = DEF_PC_W,
    parameter int unsigned INSTR_W    = DEF_INSTR_W,
    parameter int unsigned CYC_W      = DEF_CYC_W,
    parameter int unsigned STALL_W    = DEF_STALL_W,
    parameter int unsigned FIFO_DEPTH = 8
)(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fetch_valid,
    input  logic [PC_W-1:0]                   fetch_pc,
    input  logic [INSTR_W-1:0]                fetch_instr,
    input  logic                              stall,
    input  logic                              flush,
    output logic                              ret_valid,
    input  logic                              ret_ready,
    output logic [PC_W-1:0]                   ret_pc,
    output logic [INSTR_W-1:0]                ret_instr,
    output logic [CYC_W-1:0]                  ret_fetch_cyc,
    output logic [CYC_W-1:0]                  ret_retire_cyc,
    output logic [STALL_W-1:0]                ret_stall_cnt,
    output logic                              ret_flushed,
    output logic [15:0]                       drop_cnt,
    output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(NUM_STAGES + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
`ifdef TRACE_FLUSH_LOG_EN
    localparam int unsigned PUSH_N = FLUSH_UPTO + 2;
`else
    localparam int unsigned PUSH_N = 1;
`endif
    localparam int unsigned RET_IDX = PUSH_N - 1;
    localparam int unsigned DROP_W  = $clog2(PUSH_N + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [CYC_W-1:0]   fetch_cyc;
        logic [CYC_W-1:0]   retire_cyc;
        logic [STALL_W-1:0] stall_cnt;
        logic               flushed;
    } rec_t;

    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [CYC_W-1:0]   fetch_cyc;
        logic [STALL_W-1:0] stall_cnt;
    } slot_t;

    slot_t             slots      [NUM_STAGES];
    slot_t             slots_next [NUM_STAGES];
    logic [CYC_W-1:0]  cyc;
    logic [OCC_W-1:0]  occ_next;
    logic [PUSH_N-1:0] push_valid;
    rec_t [PUSH_N-1:0] push_rec;
    rec_t              head;
    logic [DROP_W-1:0] drop_n;
    logic              fifo_full;
    logic [AW:0]       fifo_count;

    // Stamps are cycle numbers: fetch_cyc is the cycle spent in F, retire_cyc the cycle
    // spent in the last stage, so the F-stage stamp is the post-edge counter value.
    always_comb begin
        if (stall && !flush) begin
            slots_next[STAGE_F] = slots[STAGE_F];
            if (slots[STAGE_F].valid && slots[STAGE_F].stall_cnt != '1)
                slots_next[STAGE_F].stall_cnt = slots[STAGE_F].stall_cnt + STALL_W'(1);
        end else begin
            slots_next[STAGE_F] = '{valid: fetch_valid, pc: fetch_pc, instr: fetch_instr,
                                    fetch_cyc: cyc + CYC_W'(1), stall_cnt: '0};
        end
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            if (stall && i <= STALL_UPTO && !(flush && i <= FLUSH_UPTO)) begin
                slots_next[i] = slots[i];
                if (slots[i].valid && slots[i].stall_cnt != '1)
                    slots_next[i].stall_cnt = slots[i].stall_cnt + STALL_W'(1);
            end else begin
                // Killed or still-held predecessors leave a bubble behind.
                slots_next[i]       = slots[i-1];
                slots_next[i].valid = slots[i-1].valid
                                      && !(flush && (i - 1) <= FLUSH_UPTO)
                                      && !(stall && (i - 1) <= STALL_UPTO);
            end
        end
    end

    always_comb begin
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) n += 32'(slots_next[i].valid);
        occ_next = OCC_W'(n);
    end

    always_comb begin
        push_valid = '0;
        push_rec   = '0;
`ifdef TRACE_FLUSH_LOG_EN
        for (int unsigned k = 0; k <= FLUSH_UPTO; k++) begin
            push_valid[k] = flush && slots[k].valid;
            push_rec[k]   = '{pc: slots[k].pc, instr: slots[k].instr,
                              fetch_cyc: slots[k].fetch_cyc, retire_cyc: cyc,
                              stall_cnt: slots[k].stall_cnt, flushed: 1'b1};
        end
`endif
        push_valid[RET_IDX] = slots[NUM_STAGES-1].valid;
        push_rec[RET_IDX]   = '{pc: slots[NUM_STAGES-1].pc, instr: slots[NUM_STAGES-1].instr,
                                fetch_cyc: slots[NUM_STAGES-1].fetch_cyc, retire_cyc: cyc,
                                stall_cnt: slots[NUM_STAGES-1].stall_cnt, flushed: 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) slots[i] <= '0;
            cyc       <= '0;
            drop_cnt  <= '0;
            occupancy <= '0;
        end else begin
            slots     <= slots_next;
            cyc       <= cyc + CYC_W'(1);
            drop_cnt  <= sat_add16(drop_cnt, 32'(drop_n));
            occupancy <= occ_next;
        end
    end

    trace_fifo #(
        .rec_t  (rec_t),
        .DEPTH  (FIFO_DEPTH),
        .PUSH_N (PUSH_N)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_rec   (push_rec),
        .out_valid  (ret_valid),
        .out_ready  (ret_ready),
        .out_rec    (head),
        .full       (fifo_full),
        .count      (fifo_count),
        .drop_n     (drop_n)
    );

    assert property (@(posedge clk) disable iff (!rst_n)
        (fifo_full == (32'(fifo_count) == FIFO_DEPTH)) && (32'(fifo_count) <= FIFO_DEPTH));

    assign ret_pc         = head.pc;
    assign ret_instr      = head.instr;
    assign ret_fetch_cyc  = head.fetch_cyc;
    assign ret_retire_cyc = head.retire_cyc;
    assign ret_stall_cnt  = head.stall_cnt;
    assign ret_flushed    = head.flushed;

endmodule
